// File: rtl/mul_pkg.sv
// mul_pkg: shared types and defaults for the RV32M sequential multiplier
package mul_pkg;
  localparam int XLEN_DEFAULT = 32;
  typedef enum logic [1:0] {MUL, MULH, MULHSU, MULHU} mul_op_e;
  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} mul_state_e;
endpackage

// File: rtl/adder_nbit.sv
// adder_nbit: N-bit Kogge-Stone prefix adder, carry-in tied to zero
module adder_nbit #(
  parameter int N = 33
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Sum,
  output logic         Cout
);
  logic [N-1:0] w_g, w_p;
  always_comb begin
    w_g = A & B;
    w_p = A ^ B;
    for (int d = 1; d < N; d = d * 2) begin
      w_g = w_g | (w_p & (w_g << d));
      w_p = w_p & (w_p << d);
    end
    Sum  = (A ^ B) ^ {w_g[N-2:0], 1'b0};
    Cout = w_g[N-1];
  end
endmodule

// File: rtl/mul_seq.sv
// mul_seq: radix-2 shift-and-add multiplier for MUL/MULH/MULHSU/MULHU,
// magnitudes multiplied unsigned then the 64-bit product negated if needed
module mul_seq
  import mul_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN) + 1;
  mul_state_e        r_state, w_next;
  mul_op_e           r_op;
  logic              r_neg;
  logic [XLEN-1:0]   r_mcand, r_mplier, r_acc_hi, r_result, w_addend;
  logic [CW-1:0]     r_count;
  logic [XLEN:0]     w_sum;
  logic              w_cout, w_sa, w_sb, w_accept, w_last;
  logic [2*XLEN-1:0] w_prod, w_fix;
  always_comb begin
    w_sa     = (op == MULH || op == MULHSU) && a[XLEN-1];
    w_sb     = op == MULH && b[XLEN-1];
    w_accept = start && (r_state == IDLE || r_state == DONE);
    w_last   = r_count == CW'(XLEN - 1);
    w_addend = r_mplier[0] ? r_mcand : '0;
    w_prod   = {r_acc_hi, r_mplier};
    w_fix    = r_neg ? ~w_prod + {{(2*XLEN-1){1'b0}}, 1'b1} : w_prod;
  end
  adder_nbit #(.N(XLEN + 1)) u_add (
    .A   ({1'b0, r_acc_hi}),
    .B   ({1'b0, w_addend}),
    .Sum (w_sum),
    .Cout(w_cout)
  );
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
  always_comb begin
    w_next = (r_state == IDLE || r_state == DONE) ? (start ? BUSY : IDLE) :
             r_state == BUSY ? (w_last ? FIX : BUSY) : DONE;
  end
  always_comb begin
    busy   = r_state == BUSY || r_state == FIX;
    done   = r_state == DONE;
    result = r_result;
  end
  // Cout can never be set with both operands zero-extended; folded in to keep the carry path explicit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= '0;
      r_acc_hi <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op     <= mul_op_e'(op);
      r_neg    <= w_sa ^ w_sb;
      r_mplier <= w_sa ? -a : a;
      r_mcand  <= w_sb ? -b : b;
      r_acc_hi <= '0;
      r_count  <= '0;
    end else if (r_state == BUSY) begin
      r_acc_hi <= {w_sum[XLEN] | w_cout, w_sum[XLEN-1:1]};
      r_mplier <= {w_sum[0], r_mplier[XLEN-1:1]};
      r_count  <= r_count + CW'(1);
    end else if (r_state == FIX) begin
      r_result <= r_op == MUL ? w_fix[XLEN-1:0] : w_fix[2*XLEN-1:XLEN];
    end
  end
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed checks of latency, sign handling, ignore/reset and back-to-back
module tb_mul_seq;
  logic        clk = 1'b0;
  logic        reset, start, busy, done;
  logic [1:0]  op;
  logic [31:0] a, b, result;
  int checks = 0;
  int failures = 0;

  localparam logic [1:0]  V_OP  [10] = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd1, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1};
  localparam logic [31:0] V_A   [10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000,
                                         32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'h00000002, 32'h00000000};
  localparam logic [31:0] V_B   [10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002, 32'h80000000,
                                         32'h00000005, 32'h00000005, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFF};
  localparam logic [31:0] V_EXP [10] = '{32'h00000000, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFF, 32'h40000000,
                                         32'hFFFFFFFF, 32'hFFFFFFF1, 32'h00000001, 32'h00000001, 32'h00000000};

  mul_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
  endtask

  task automatic wait_done(output int cyc, output bit bok);
    cyc = -1; bok = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin cyc = c; break; end
      if (!busy) bok = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; op = 2'd0; a = 32'd7; b = 32'd6;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=00000000", result); end
    reset = 1'b0; start = 1'b0;
  endtask

  task automatic test_mul_basic;
    int cyc; bit bok;
    start_op(2'd0, 32'd7, 32'd6);
    wait_done(cyc, bok);
    checks++; if (cyc !== 34) begin failures++; $display("FAIL basic_latency got=%0d exp=34", cyc); end
    checks++; if (bok !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", bok); end
    checks++; if (result !== 32'h2A) begin failures++; $display("FAIL basic_result got=%h exp=0000002a", result); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    checks++; if (result !== 32'h2A) begin failures++; $display("FAIL basic_hold got=%h exp=0000002a", result); end
  endtask

  task automatic test_signs;
    int cyc; bit bok;
    for (int i = 0; i < 10; i++) begin
      start_op(V_OP[i], V_A[i], V_B[i]);
      wait_done(cyc, bok);
      checks++;
      if (cyc !== 34) begin failures++; $display("FAIL sign%0d_latency got=%0d exp=34", i, cyc); end
      checks++;
      if (result !== V_EXP[i]) begin
        failures++; $display("FAIL sign%0d_result op=%0d got=%h exp=%h", i, V_OP[i], result, V_EXP[i]);
      end
    end
  endtask

  task automatic test_start_ignored;
    int cyc = -1;
    start_op(2'd0, 32'd123, 32'd456);
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
      if (c == 10) start_op(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
      if (c == 11) start = 1'b0;
      if (done) begin cyc = c; break; end
    end
    checks++; if (cyc !== 34) begin failures++; $display("FAIL ignored_latency got=%0d exp=34", cyc); end
    checks++; if (result !== 32'h0000DB18) begin failures++; $display("FAIL ignored_result got=%h exp=0000db18", result); end
  endtask

  task automatic test_reset_mid;
    int cyc; bit bok; bit seen = 1'b0;
    @(posedge clk); #1;
    start_op(2'd0, 32'd9, 32'd9);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL midreset_result got=%h exp=00000000", result); end
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midreset_no_done got=%b exp=0", seen); end
    start_op(2'd0, 32'd9, 32'd9);
    wait_done(cyc, bok);
    checks++; if (cyc !== 34) begin failures++; $display("FAIL after_reset_latency got=%0d exp=34", cyc); end
    checks++; if (result !== 32'h51) begin failures++; $display("FAIL after_reset_result got=%h exp=00000051", result); end
  endtask

  task automatic test_back_to_back;
    int d1 = -1, d2 = -1;
    logic [31:0] r1 = '0, r2 = '0;
    bit gap_ok = 1'b0;
    @(posedge clk); #1;
    start_op(2'd0, 32'd3, 32'd4);
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin a = 32'd5; b = 32'd5; end
      if (c == 35) gap_ok = !done && busy;
      if (done) begin
        if (d1 < 0) begin d1 = c; r1 = result; end
        else begin d2 = c; r2 = result; start = 1'b0; break; end
      end
    end
    start = 1'b0;
    checks++; if (d1 !== 34) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=34", d1); end
    checks++; if (r1 !== 32'hC) begin failures++; $display("FAIL b2b_first_result got=%h exp=0000000c", r1); end
    checks++; if (gap_ok !== 1'b1) begin failures++; $display("FAIL b2b_no_bubble got=%b exp=1", gap_ok); end
    checks++; if (d2 !== 68) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=68", d2); end
    checks++; if (r2 !== 32'h19) begin failures++; $display("FAIL b2b_second_result got=%h exp=00000019", r2); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b%b exp=00", done, busy); end
  endtask

  initial begin
    test_reset;
    test_mul_basic;
    test_signs;
    test_start_ignored;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mul_seq.md
# mul_seq

Iterative radix-2 shift-and-add multiplier implementing the RV32M multiply group (MUL, MULH, MULHSU, MULHU). Sits in the execute stage beside the ALU. It takes rs1/rs2 operands on a start pulse and returns the selected 32-bit half of the 64-bit product after a fixed latency. It reuses the team's prefix-adder style for its per-iteration XLEN+1-bit accumulate.

## Interface
- XLEN, 32, operand/result width; latency scales as XLEN+2.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE or DONE.
- op  in  2  funct3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- a  in  XLEN  rs1 operand, captured with start.
- b  in  XLEN  rs2 operand, captured with start.
- busy  out  1  high while a multiply is in progress.
- done  out  1  one-cycle pulse; result valid.
- result  out  XLEN  selected product half; held stable until the next accepted start or reset.

## Operation
- States: IDLE, BUSY, FIX, DONE.
- IDLE/DONE + start: capture op.
  - Capture |a| if a is signed (op 01, 10) and a[XLEN-1]=1, else a.
  - Capture |b| if b is signed (op 01 only) and b[XLEN-1]=1, else b.
  - neg = sign_a XOR sign_b, where sign_x is counted only for signed operands.
  - Clear the accumulator and set count=0. Go to BUSY.
- Magnitude of 0x80000000 is 0x80000000 as unsigned; no special case.
- BUSY, each cycle:
  - If mplier[0]=1, form the XLEN+1-bit sum acc_hi + mcand; otherwise form acc_hi + 0.
  - Shift {carry, sum, mplier} right by one into {acc_hi, mplier}.
  - count++. After XLEN iterations, go to FIX.
- FIX: if neg, replace the 2·XLEN product with its two's complement. Go to DONE.
- DONE:
  - done=1, busy=0.
  - result = product[XLEN-1:0] for MUL; product[2XLEN-1:XLEN] otherwise.
  - Next state: BUSY if start, else IDLE.
- MUL ignores signedness; low half is identical for all sign interpretations.
- start while BUSY or FIX: ignored, with no effect on the in-flight operation.
- reset, any state including mid-operation, next edge:
  - state=IDLE, busy=0, done=0, result=0, count=0, accumulator=0.
  - The in-flight operation is discarded.
- start and reset in the same cycle: reset wins.

## Timing
- start accepted in cycle 0.
- busy=1 in cycles 1..XLEN+1 (BUSY cycles 1..XLEN, FIX cycle XLEN+1).
- done=1 in cycle XLEN+2 (34 for XLEN=32); result is registered and valid in that cycle.
- Back-to-back: start in the DONE cycle begins the next operation with no bubble; its done arrives XLEN+2 cycles later.
- Reset values: busy=0, done=0, result=0.
- Fixed latency; no early termination on zero operands.

## Structure
- Package mul_pkg:
  - typedef enum mul_op_e {MUL, MULH, MULHSU, MULHU}, 2 bits.
  - typedef enum mul_state_e {IDLE, BUSY, FIX, DONE}.
  - localparam default XLEN.
- Sub-module adder_nbit (parameter N):
  - Inputs: A, B; outputs: Sum, Cout.
  - Carry-in 0, prefix carry network.
  - Instantiated with N=XLEN+1 for the accumulate step.
- FIX negation uses a separate inline two's complement (~p + 1); it is not routed through adder_nbit.
- Counter width: $clog2(XLEN)+1.

## Test plan
- MUL, a=7, b=6 -> done only in cycle 34, result=0x0000002A, busy high cycles 1–33.
- a=b=0xFFFFFFFF -> MULH 0x00000000; MULHU 0xFFFFFFFE; MUL 0x00000001.
- MULHSU, a=0x80000000, b=0x00000002 -> result 0xFFFFFFFF; MULH a=b=0x80000000 -> 0x40000000.
- MULH a=0xFFFFFFFD (-3), b=0x00000005 -> 0xFFFFFFFF; MUL on the same operands -> 0xFFFFFFF1.
- start with new operands at cycle 10 of a busy op -> ignored, original result returned at cycle 34. reset at cycle 20 -> busy=0, result=0 next cycle, no done pulse.
- start held high through DONE (MUL 3×4, then MUL 5×5) -> results 0x0000000C and 0x00000019 at cycles 34 and 68.
